// File: rtl/t01_sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: FSM states, effect IDs
// and the per-effect step/tick/half-period table.
package t01_sfx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SFX_DROP    = 2'd0,
        SFX_CLEAR12 = 2'd1,
        SFX_CLEAR3  = 2'd2,
        SFX_CLEAR4  = 2'd3
    } sfx_id_e;

    localparam int HP_W   = 12;
    localparam int STEP_W = 2;
    localparam int TPS_W  = 3;

    // Half period of the tone, in clk cycles, for a given effect and step.
    function automatic logic [HP_W-1:0] half_period(input logic [1:0] id, input logic [STEP_W-1:0] step);
        logic [HP_W-1:0] hp;
        case ({id, step})
            {SFX_CLEAR12, 2'd0}: hp = 12'd3000;
            {SFX_CLEAR12, 2'd1}: hp = 12'd2500;
            {SFX_CLEAR12, 2'd2}: hp = 12'd2000;
            {SFX_CLEAR3,  2'd0}: hp = 12'd3000;
            {SFX_CLEAR3,  2'd1}: hp = 12'd2500;
            {SFX_CLEAR3,  2'd2}: hp = 12'd2000;
            {SFX_CLEAR3,  2'd3}: hp = 12'd1500;
            {SFX_CLEAR4,  2'd0}: hp = 12'd2000;
            {SFX_CLEAR4,  2'd1}: hp = 12'd1500;
            {SFX_CLEAR4,  2'd2}: hp = 12'd1000;
            {SFX_CLEAR4,  2'd3}: hp = 12'd750;
            default:             hp = 12'd4000;
        endcase
        return hp;
    endfunction

    function automatic logic [STEP_W-1:0] last_step(input logic [1:0] id);
        case (id)
            SFX_CLEAR12: return 2'd2;
            SFX_CLEAR3:  return 2'd3;
            SFX_CLEAR4:  return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic [TPS_W-1:0] ticks_per_step(input logic [1:0] id);
        return (id == SFX_CLEAR4) ? 3'd6 : 3'd4;
    endfunction

    function automatic logic [1:0] highest(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/t01_sfx_tone.sv
// Square-wave tone generator: counts clk cycles and flips the level every
// half period; can be parked high, restarted from level 0, or re-phased.
module t01_sfx_tone
    import t01_sfx_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic            restart_i,
    input  logic            en_i,
    input  logic [HP_W-1:0] half_period_i,
    output logic            level_o
);

    logic [HP_W-1:0] cnt_q;
    logic            level_q;

    // Restart clears only the count so a shorter next half period cannot be overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else if (clear_i) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else if (load_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q   <= '0;
        end else if (en_i) begin
            if (cnt_q == half_period_i - 12'd1) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q   <= cnt_q + 12'd1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/t01_sfx_scheduler.sv
// Sound-effect scheduler: plays prioritised effects over the background
// music, with preemption, a one-tick gap between queued effects and abort.
module t01_sfx_scheduler
    import t01_sfx_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sfx_req,
    input  logic       gameover,
    input  logic       music_in,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       sfx_done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_e            state_q, state_d;
    logic [3:0]        pending_q, pending_d;
    logic [1:0]        id_q, id_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TPS_W-1:0]  tps_q, tps_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              busy_q, done_q, done_d;

    logic              tick;
    logic              start_en;
    logic [1:0]        start_id;
    logic [1:0]        req_top;
    logic [3:0]        merged;
    logic              tone_clear, tone_load, tone_restart, tone_en, tone_level;
    logic [HP_W-1:0]   hp_cur;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign req_top = highest(sfx_req);
    assign merged  = pending_q | sfx_req;
    assign hp_cur  = half_period(id_q, step_q);
    assign tone_en = (state_q == S_PLAY);

    // Next-state logic; a start from any state funnels through start_en/start_id.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        id_d         = id_q;
        step_d       = step_q;
        tps_d        = tps_q;
        tick_cnt_d   = tick_cnt_q;
        done_d       = 1'b0;
        start_en     = 1'b0;
        start_id     = 2'd0;
        tone_clear   = 1'b0;
        tone_restart = 1'b0;

        if (gameover) begin
            state_d    = S_IDLE;
            pending_d  = '0;
            id_d       = 2'd0;
            step_d     = '0;
            tps_d      = '0;
            tick_cnt_d = '0;
            tone_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|sfx_req) begin
                        start_en  = 1'b1;
                        start_id  = req_top;
                        pending_d = sfx_req & ~(4'b0001 << req_top);
                    end
                end
                S_PLAY: begin
                    if ((|sfx_req) && (req_top > id_q)) begin
                        start_en  = 1'b1;
                        start_id  = req_top;
                        pending_d = merged & ~(4'b0001 << req_top) & ~(4'b0001 << id_q);
                    end else begin
                        pending_d  = merged & ~(4'b0001 << id_q);
                        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
                        if (tick) begin
                            if (tps_q == ticks_per_step(id_q) - TPS_W'(1)) begin
                                tps_d = '0;
                                if (step_q == last_step(id_q)) begin
                                    done_d     = 1'b1;
                                    step_d     = '0;
                                    tone_clear = 1'b1;
                                    state_d    = (|pending_d) ? S_GAP : S_IDLE;
                                    id_d       = (|pending_d) ? highest(pending_d) : 2'd0;
                                end else begin
                                    step_d       = step_q + STEP_W'(1);
                                    tone_restart = 1'b1;
                                end
                            end else begin
                                tps_d = tps_q + TPS_W'(1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    pending_d  = merged;
                    id_d       = highest(merged);
                    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
                    if (tick) begin
                        start_en  = 1'b1;
                        start_id  = highest(merged);
                        pending_d = merged & ~(4'b0001 << highest(merged));
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (start_en) begin
                state_d    = S_PLAY;
                id_d       = start_id;
                step_d     = '0;
                tps_d      = '0;
                tick_cnt_d = '0;
            end
        end
    end

    assign tone_load = start_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            id_q       <= 2'd0;
            step_q     <= '0;
            tps_q      <= '0;
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            id_q       <= id_d;
            step_q     <= step_d;
            tps_q      <= tps_d;
            tick_cnt_q <= tick_cnt_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
        end
    end

    t01_sfx_tone u_tone (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (tone_clear),
        .load_i        (tone_load),
        .restart_i     (tone_restart),
        .en_i          (tone_en),
        .half_period_i (hp_cur),
        .level_o       (tone_level)
    );

    // Music passes through whenever no effect owns the speaker or the game is over.
    assign audio_out = gameover            ? music_in   :
                       (state_q == S_PLAY) ? tone_level :
                       (state_q == S_GAP)  ? 1'b1       : music_in;
    assign busy      = busy_q;
    assign active_id = id_q;
    assign sfx_done  = done_q;

endmodule

// File: tb/tb_t01_sfx_scheduler.sv
// Directed bench for the sound-effect scheduler: a fast-tick instance for
// sequencing/priority/abort and a slow-tick instance for tone timing.
module tb_t01_sfx_scheduler;

    logic       clk;
    logic       rst;
    logic       musicIn;
    logic [3:0] reqA, reqB;
    logic       goA, goB;
    logic       audA, audB, busyA, busyB, doneA, doneB;
    logic [1:0] idA, idB;

    int checks = 0;
    int errors = 0;
    int doneCountA = 0;
    int doneStart;

    t01_sfx_scheduler #(.TICK_DIV(10)) dutA (
        .clk       (clk),
        .rst       (rst),
        .sfx_req   (reqA),
        .gameover  (goA),
        .music_in  (musicIn),
        .audio_out (audA),
        .busy      (busyA),
        .active_id (idA),
        .sfx_done  (doneA)
    );

    t01_sfx_scheduler #(.TICK_DIV(10000)) dutB (
        .clk       (clk),
        .rst       (rst),
        .sfx_req   (reqB),
        .gameover  (goB),
        .music_in  (musicIn),
        .audio_out (audB),
        .busy      (busyB),
        .active_id (idB),
        .sfx_done  (doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counting completion pulses lets us prove none appeared in a window.
    always @(negedge clk) begin
        if (doneA === 1'b1) doneCountA <= doneCountA + 1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one-cycle request pulses; returns 1 ns after the edge that sampled them.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        reqA = a;
        reqB = b;
        @(posedge clk);
        #1;
        reqA = 4'b0000;
        reqB = 4'b0000;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; musicIn = 1'b1;
        reqA = 4'b0000; reqB = 4'b0000; goA = 1'b0; goB = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        checkOutput("rst_id", 32'(idA), 32'd0);
        checkOutput("rst_done", 32'(doneA), 32'd0);
        checkOutput("rst_aud_music1", 32'(audA), 32'd1);
        musicIn = 1'b0; #1;
        checkOutput("rst_aud_music0", 32'(audA), 32'd0);
        @(negedge clk) rst = 1'b0;
        waitCycles(2);

        $display("[TB] single drop effect");
        musicIn = 1'b1;
        doneStart = doneCountA;
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("drop_start_busy", 32'(busyA), 32'd1);
        checkOutput("drop_start_aud", 32'(audA), 32'd0);
        waitCycles(39);
        checkOutput("drop_c39_busy", 32'(busyA), 32'd1);
        checkOutput("drop_c39_done", 32'(doneA), 32'd0);
        waitCycles(1);
        checkOutput("drop_c40_busy", 32'(busyA), 32'd0);
        checkOutput("drop_c40_done", 32'(doneA), 32'd1);
        waitCycles(1);
        checkOutput("drop_c41_done", 32'(doneA), 32'd0);
        checkOutput("drop_done_count", 32'(doneCountA), 32'(doneStart + 1));
        musicIn = 1'b0; #1;
        checkOutput("drop_idle_music0", 32'(audA), 32'd0);
        musicIn = 1'b1; #1;
        checkOutput("drop_idle_music1", 32'(audA), 32'd1);
        waitCycles(3);

        $display("[TB] simultaneous clear3 + drop");
        applyStimulus(4'b0101, 4'b0000);
        checkOutput("dual_start_id", 32'(idA), 32'd2);
        checkOutput("dual_start_busy", 32'(busyA), 32'd1);
        checkOutput("dual_start_aud", 32'(audA), 32'd0);
        waitCycles(159);
        checkOutput("dual_c159_id", 32'(idA), 32'd2);
        checkOutput("dual_c159_done", 32'(doneA), 32'd0);
        waitCycles(1);
        checkOutput("dual_c160_done", 32'(doneA), 32'd1);
        checkOutput("dual_c160_busy", 32'(busyA), 32'd1);
        musicIn = 1'b0; #1;
        checkOutput("dual_gap_aud", 32'(audA), 32'd1);
        waitCycles(9);
        checkOutput("dual_c169_busy", 32'(busyA), 32'd1);
        checkOutput("dual_c169_aud", 32'(audA), 32'd1);
        waitCycles(1);
        checkOutput("dual_c170_busy", 32'(busyA), 32'd1);
        checkOutput("dual_c170_id", 32'(idA), 32'd0);
        checkOutput("dual_c170_done", 32'(doneA), 32'd0);
        musicIn = 1'b1; #1;
        checkOutput("dual_c170_aud", 32'(audA), 32'd0);
        waitCycles(39);
        checkOutput("dual_c209_busy", 32'(busyA), 32'd1);
        waitCycles(1);
        checkOutput("dual_c210_busy", 32'(busyA), 32'd0);
        checkOutput("dual_c210_done", 32'(doneA), 32'd1);
        waitCycles(3);

        $display("[TB] preemption of drop by clear1-2");
        doneStart = doneCountA;
        applyStimulus(4'b0001, 4'b0000);
        waitCycles(19);
        checkOutput("pre_c19_id", 32'(idA), 32'd0);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("pre_c20_id", 32'(idA), 32'd1);
        checkOutput("pre_c20_busy", 32'(busyA), 32'd1);
        waitCycles(119);
        checkOutput("pre_c139_busy", 32'(busyA), 32'd1);
        checkOutput("pre_no_early_done", 32'(doneCountA), 32'(doneStart));
        waitCycles(1);
        checkOutput("pre_c140_done", 32'(doneA), 32'd1);
        checkOutput("pre_c140_busy", 32'(busyA), 32'd0);
        waitCycles(20);
        checkOutput("pre_no_replay", 32'(busyA), 32'd0);
        checkOutput("pre_done_count", 32'(doneCountA), 32'(doneStart + 1));

        $display("[TB] gameover abort");
        applyStimulus(4'b1001, 4'b0000);
        checkOutput("go_start_id", 32'(idA), 32'd3);
        waitCycles(30);
        doneStart = doneCountA;
        goA = 1'b1;
        waitCycles(1);
        checkOutput("go_busy", 32'(busyA), 32'd0);
        checkOutput("go_id", 32'(idA), 32'd0);
        musicIn = 1'b0; #1;
        checkOutput("go_aud_music", 32'(audA), 32'd0);
        musicIn = 1'b1;
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("go_req_ignored", 32'(busyA), 32'd0);
        waitCycles(5);
        goA = 1'b0;
        waitCycles(50);
        checkOutput("go_still_idle", 32'(busyA), 32'd0);
        checkOutput("go_no_done", 32'(doneCountA), 32'(doneStart));
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("go_after_id", 32'(idA), 32'd1);
        waitCycles(120);
        checkOutput("go_after_done", 32'(doneA), 32'd1);
        waitCycles(15);
        checkOutput("go_pending_cleared", 32'(busyA), 32'd0);

        $display("[TB] reset during gap");
        applyStimulus(4'b0101, 4'b0000);
        waitCycles(164);
        checkOutput("rg_in_gap", 32'(busyA), 32'd1);
        doneStart = doneCountA;
        #2 rst = 1'b1;
        #1;
        checkOutput("rg_busy", 32'(busyA), 32'd0);
        checkOutput("rg_id", 32'(idA), 32'd0);
        checkOutput("rg_done", 32'(doneA), 32'd0);
        checkOutput("rg_aud_music1", 32'(audA), 32'd1);
        musicIn = 1'b0; #1;
        checkOutput("rg_aud_music0", 32'(audA), 32'd0);
        #2 rst = 1'b0;
        musicIn = 1'b1;
        waitCycles(60);
        checkOutput("rg_stays_idle", 32'(busyA), 32'd0);
        checkOutput("rg_no_done", 32'(doneCountA), 32'(doneStart));

        $display("[TB] tone timing at slow tick");
        applyStimulus(4'b0000, 4'b0001);
        checkOutput("tone_start_aud", 32'(audB), 32'd0);
        checkOutput("tone_start_busy", 32'(busyB), 32'd1);
        for (int k = 0; k < 10; k++) begin
            waitCycles(3999);
            checkOutput($sformatf("tone_seg%0d_end", k), 32'(audB), 32'(k % 2));
            waitCycles(1);
            if (k < 9) begin
                checkOutput($sformatf("tone_seg%0d_start", k + 1), 32'(audB), 32'((k + 1) % 2));
            end else begin
                checkOutput("tone_end_done", 32'(doneB), 32'd1);
                checkOutput("tone_end_busy", 32'(busyB), 32'd0);
                checkOutput("tone_end_music", 32'(audB), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
